imm_gen_pipe: RTL and testbench

//  Pipelined immediate generator for all RISC-V base formats (I, S, B, U, J).

---
 rtl/imm_gen_pkg.sv | 30 +++
 rtl/imm_gen_decode.sv | 47 ++++
 rtl/imm_gen_pipe.sv | 117 +++++++++++
 tb/tb_imm_gen_pipe.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/imm_gen_pkg.sv
// Shared encodings for the pipelined immediate generator: format codes,
// RISC-V base opcodes and the parameter legality check.
package imm_gen_pkg;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_R    = 3'd6
  } fmt_t;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  function automatic bit xlen_ok(input int xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage

// File: rtl/imm_gen_decode.sv
// Combinational immediate decode: instruction word -> {imm, fmt, illegal}.
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output fmt_t            fmt,
  output logic            illegal
);

  logic [31:0] imm32;

  always_comb begin
    imm32   = '0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    case (instr[6:0])
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: begin
        fmt   = FMT_I;
        imm32 = {{20{instr[31]}}, instr[31:20]};
      end
      OP_STORE: begin
        fmt   = FMT_S;
        imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OP_BRANCH: begin
        fmt   = FMT_B;
        imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        fmt   = FMT_U;
        imm32 = {instr[31:12], 12'b0};
      end
      OP_JAL: begin
        fmt   = FMT_J;
        imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      OP_REG:  fmt = FMT_R;
      default: illegal = 1'b1;
    endcase
    // bit 31 of every 32-bit form already equals instr[31], so a signed widen finishes sext
    imm = XLEN'($signed(imm32));
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator with a DEPTH-entry output skid buffer.
// Define IMM_GEN_ERR_CNT_EN to add the saturating illegal-opcode counter.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output fmt_t            out_fmt,
  output logic            out_illegal
`ifdef IMM_GEN_ERR_CNT_EN
  ,
  output logic [15:0]     err_count
`endif
);

  localparam int CW = $clog2(DEPTH + 1);

  if (!xlen_ok(XLEN) || !(DEPTH == 1 || DEPTH == 2)) begin : g_bad_param
    $error("imm_gen_pipe: unsupported XLEN/DEPTH");
  end

  logic [XLEN-1:0] dec_imm;
  fmt_t            dec_fmt;
  logic            dec_ill;

  imm_decode #(.XLEN(XLEN)) u_dec (
    .instr   (in_instr),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_ill)
  );

  logic [DEPTH-1:0][XLEN-1:0] imm_q, imm_d;
  logic [DEPTH-1:0][2:0]      fmt_q, fmt_d;
  logic [DEPTH-1:0]           ill_q, ill_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic                       rdy_q, rdy_d;
  logic                       push, pop;

  // rdy_q holds !full for the next cycle; reset masks it so nothing lands during reset
  assign in_ready    = rdy_q && !reset;
  assign push        = in_valid && in_ready;
  assign out_valid   = (cnt_q != '0);
  assign pop         = out_valid && out_ready;
  assign out_imm     = out_valid ? imm_q[0] : '0;
  assign out_fmt     = out_valid ? fmt_t'(fmt_q[0]) : FMT_NONE;
  assign out_illegal = out_valid && ill_q[0];

  // Head lives at entry 0; a pop shifts the rest down, a push fills the first free slot.
  always_comb begin
    imm_d = imm_q;
    fmt_d = fmt_q;
    ill_d = ill_q;
    cnt_d = cnt_q;
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        imm_d[i] = imm_q[i+1];
        fmt_d[i] = fmt_q[i+1];
        ill_d[i] = ill_q[i+1];
      end
      cnt_d = cnt_q - CW'(1);
    end
    if (push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CW'(i) == cnt_d) begin
          imm_d[i] = dec_imm;
          fmt_d[i] = dec_fmt;
          ill_d[i] = dec_ill;
        end
      end
      cnt_d = cnt_d + CW'(1);
    end
    rdy_d = (cnt_d != CW'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      imm_q <= '0;
      fmt_q <= '0;
      ill_q <= '0;
      cnt_q <= '0;
      rdy_q <= 1'b1;
    end else begin
      imm_q <= imm_d;
      fmt_q <= fmt_d;
      ill_q <= ill_d;
      cnt_q <= cnt_d;
      rdy_q <= rdy_d;
    end
  end

`ifdef IMM_GEN_ERR_CNT_EN
  logic [15:0] err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (push && dec_ill && (err_q != 16'hFFFF)) err_d = err_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) err_q <= '0;
    else       err_q <= err_d;
  end

  assign err_count = err_q;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe (XLEN=64, DEPTH=2); counter checks run
// only when IMM_GEN_ERR_CNT_EN is defined.
module tb_imm_gen_pipe;
  import imm_gen_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_imm;
  fmt_t        out_fmt;
  logic        out_illegal;
`ifdef IMM_GEN_ERR_CNT_EN
  logic [15:0] err_count;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(64), .DEPTH(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_imm     (out_imm),
    .out_fmt     (out_fmt),
    .out_illegal (out_illegal)
`ifdef IMM_GEN_ERR_CNT_EN
    ,
    .err_count   (err_count)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  localparam int NV = 9;
  logic [31:0] v_instr [NV] = '{32'h0000007F, 32'h12345037, 32'hFFF00093, 32'hFE000EE3,
                                32'h00112623, 32'hFFDFF0EF, 32'h00208033, 32'h80000017,
                                32'h8000A003};
  logic [63:0] v_imm   [NV] = '{64'h0, 64'h12345000, 64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFC,
                                64'hC, 64'hFFFFFFFF_FFFFFFFC, 64'h0, 64'hFFFFFFFF_80000000,
                                64'hFFFFFFFF_FFFFF800};
  logic [2:0]  v_fmt   [NV] = '{3'd0, 3'd4, 3'd1, 3'd3, 3'd2, 3'd5, 3'd6, 3'd4, 3'd1};
  logic        v_ill   [NV] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  logic [31:0] bp_instr [3] = '{32'h12345037, 32'h00112623, 32'hFFDFF0EF};
  logic [63:0] bp_imm   [3] = '{64'h12345000, 64'hC, 64'hFFFFFFFF_FFFFFFFC};

  initial begin
    logic [63:0] got_q[$];
    logic        rdy_seen [3];
    logic        acc;
    int          idx;

    reset = 1'b1; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_imm", out_imm, 64'd0);
    chk("rst_out_fmt", 64'(out_fmt), 64'd0);
    chk("rst_out_ill", 64'(out_illegal), 64'd0);
    chk("rst_ready_after", 64'(in_ready), 64'd1);
`ifdef IMM_GEN_ERR_CNT_EN
    chk("rst_err", 64'(err_count), 64'd0);
`endif
    @(posedge clk); #1;

    // one instruction at a time, head must show it one cycle after the push
    for (int k = 0; k < NV; k++) begin
      in_valid = 1'b1; in_instr = v_instr[k]; out_ready = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_valid", k), 64'(out_valid), 64'd1);
      chk($sformatf("v%0d_imm", k), out_imm, v_imm[k]);
      chk($sformatf("v%0d_fmt", k), 64'(out_fmt), 64'(v_fmt[k]));
      chk($sformatf("v%0d_ill", k), 64'(out_illegal), 64'(v_ill[k]));
`ifdef IMM_GEN_ERR_CNT_EN
      chk($sformatf("v%0d_err", k), 64'(err_count), 64'd1);
`endif
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("drain_empty", 64'(out_valid), 64'd0);
    @(posedge clk); #1;

    // backpressure: 2 accepts then stall, release after a few cycles
    out_ready = 1'b0; idx = 0;
    in_valid = 1'b1; in_instr = bp_instr[0];
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (cyc < 3) rdy_seen[cyc] = in_ready;
      if (cyc == 4) chk("bp_hold_imm", out_imm, bp_imm[0]);
      if (out_valid && out_ready) got_q.push_back(out_imm);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        if (idx < 3) in_instr = bp_instr[idx];
        else in_valid = 1'b0;
      end
      if (cyc == 5) out_ready = 1'b1;
      if (got_q.size() == 3 && idx == 3) break;
    end
    in_valid = 1'b0;
    chk("bp_rdy0", 64'(rdy_seen[0]), 64'd1);
    chk("bp_rdy1", 64'(rdy_seen[1]), 64'd1);
    chk("bp_rdy2", 64'(rdy_seen[2]), 64'd0);
    chk("bp_accepted", 64'(idx), 64'd3);
    chk("bp_count", 64'(got_q.size()), 64'd3);
    for (int k = 0; k < 3; k++)
      chk($sformatf("bp_order%0d", k), (k < got_q.size()) ? got_q[k] : 64'hDEAD, bp_imm[k]);
    @(negedge clk);
    chk("bp_no_dup", 64'(out_valid), 64'd0);
    @(posedge clk); #1;

    // mid-operation reset with two entries buffered and a push in the reset cycle
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h12345037;
    @(posedge clk); #1 in_instr = 32'h00112623;
    @(posedge clk); #1 in_instr = 32'h0000007F; reset = 1'b1;
    @(negedge clk);
    chk("mr_full_valid", 64'(out_valid), 64'd1);
    chk("mr_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1 reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("mr_out_valid", 64'(out_valid), 64'd0);
    chk("mr_out_imm", out_imm, 64'd0);
    chk("mr_in_ready_after", 64'(in_ready), 64'd1);
`ifdef IMM_GEN_ERR_CNT_EN
    chk("mr_err", 64'(err_count), 64'd0);
`endif
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    chk("mr_dropped", 64'(out_valid), 64'd0);
    @(posedge clk); #1;

`ifdef IMM_GEN_ERR_CNT_EN
    in_valid = 1'b1; in_instr = 32'h0000007F; out_ready = 1'b1;
    repeat (70000) @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("err_sat", 64'(err_count), 64'hFFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
